// File: rtl/ps2_frame_receiver.sv
// PS/2 device-to-host frame receiver with input deglitching, frame checks, timeout and byte history.
// Optional make/break decode outputs are enabled by defining PS2_BREAK_DECODE_EN.
module ps2_frame_receiver #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000,
  parameter int HIST_BYTES  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    kclk,
  input  logic                    kdata,
  output logic [8*HIST_BYTES-1:0] keycodeout,
  output logic [7:0]              byte_out,
  output logic                    byte_valid,
  output logic                    frame_err,
  output logic [1:0]              err_code,
  output logic                    busy
`ifdef PS2_BREAK_DECODE_EN
  ,
  output logic [7:0]              key_code,
  output logic                    key_release,
  output logic                    key_ext,
  output logic                    key_valid
`endif
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int KW = 8 * HIST_BYTES;

  typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1, CHECK = 2'd2} state_t;

  // Odd parity holds when data plus parity bit has an odd number of ones.
  function automatic logic odd_parity_ok(input logic [8:0] v);
    return ^v;
  endfunction

  logic          kclk_s1_r, kclk_s2_r, kdata_s1_r, kdata_s2_r;
  logic          kclk_f_r, kclk_f_d_r, kdata_f_r;
  logic [FW-1:0] kclk_cnt_r, kdata_cnt_r;
  logic          fall_evt_r, fall_data_r;

  state_t        state_r, state_s;
  logic [3:0]    bitcnt_r, bitcnt_s;
  logic [9:0]    shift_r, shift_s;
  logic [TW-1:0] to_cnt_r, to_cnt_s;
  logic [KW-1:0] kc_s;
  logic [KW+7:0] kc_ext_s;
  logic [7:0]    byte_out_s;
  logic [1:0]    err_code_s;
  logic          byte_valid_s, frame_err_s, busy_s;
`ifdef PS2_BREAK_DECODE_EN
  logic          rel_r, ext_r, rel_s, ext_s;
  logic [7:0]    key_code_s;
  logic          key_release_s, key_ext_s, key_valid_s;
`endif

  // Synchronise, deglitch and detect filtered kclk falling edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      {kclk_s1_r, kclk_s2_r, kdata_s1_r, kdata_s2_r} <= 4'b1111;
      kclk_f_r    <= 1'b1;
      kclk_f_d_r  <= 1'b1;
      kdata_f_r   <= 1'b1;
      kclk_cnt_r  <= '0;
      kdata_cnt_r <= '0;
      fall_evt_r  <= 1'b0;
      fall_data_r <= 1'b1;
    end else begin
      kclk_s1_r  <= kclk;
      kclk_s2_r  <= kclk_s1_r;
      kdata_s1_r <= kdata;
      kdata_s2_r <= kdata_s1_r;
      if (kclk_s2_r == kclk_f_r) begin
        kclk_cnt_r <= '0;
      end else if (kclk_cnt_r == FW'(FILTER_LEN - 1)) begin
        kclk_f_r   <= kclk_s2_r;
        kclk_cnt_r <= '0;
      end else begin
        kclk_cnt_r <= kclk_cnt_r + FW'(1);
      end
      if (kdata_s2_r == kdata_f_r) begin
        kdata_cnt_r <= '0;
      end else if (kdata_cnt_r == FW'(FILTER_LEN - 1)) begin
        kdata_f_r   <= kdata_s2_r;
        kdata_cnt_r <= '0;
      end else begin
        kdata_cnt_r <= kdata_cnt_r + FW'(1);
      end
      kclk_f_d_r  <= kclk_f_r;
      fall_evt_r  <= kclk_f_d_r & ~kclk_f_r;
      fall_data_r <= kdata_f_r;
    end
  end

  // Next-state logic; the frame is judged on the stop-bit edge so results land in the CHECK cycle.
  always_comb begin
    state_s      = state_r;
    bitcnt_s     = bitcnt_r;
    shift_s      = shift_r;
    to_cnt_s     = to_cnt_r;
    kc_s         = keycodeout;
    kc_ext_s     = {keycodeout, shift_r[8:1]};
    byte_out_s   = byte_out;
    err_code_s   = err_code;
    byte_valid_s = 1'b0;
    frame_err_s  = 1'b0;
`ifdef PS2_BREAK_DECODE_EN
    rel_s         = rel_r;
    ext_s         = ext_r;
    key_code_s    = key_code;
    key_release_s = key_release;
    key_ext_s     = key_ext;
    key_valid_s   = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        if (fall_evt_r && !fall_data_r) begin
          state_s  = RECV;
          bitcnt_s = 4'd0;
          to_cnt_s = TW'(1);
        end else begin
          state_s  = IDLE;
          to_cnt_s = '0;
        end
      end
      RECV: begin
        if (fall_evt_r) begin
          shift_s  = {fall_data_r, shift_r[9:1]};
          bitcnt_s = bitcnt_r + 4'd1;
          to_cnt_s = TW'(1);
          kc_ext_s = {keycodeout, shift_s[7:0]};
          if (bitcnt_r == 4'd9) begin
            state_s = CHECK;
            if (!shift_s[9]) begin
              frame_err_s = 1'b1;
              err_code_s  = 2'b01;
            end else if (!odd_parity_ok(shift_s[8:0])) begin
              frame_err_s = 1'b1;
              err_code_s  = 2'b10;
            end else begin
              byte_valid_s = 1'b1;
              byte_out_s   = shift_s[7:0];
              kc_s         = kc_ext_s[KW-1:0];
            end
          end else begin
            state_s = RECV;
          end
        end else if (to_cnt_r == TW'(TIMEOUT_CYC - 1)) begin
          state_s     = IDLE;
          frame_err_s = 1'b1;
          err_code_s  = 2'b11;
        end else begin
          to_cnt_s = to_cnt_r + TW'(1);
        end
      end
      CHECK: begin
        state_s  = IDLE;
        to_cnt_s = '0;
      end
      default: begin
        state_s  = IDLE;
        to_cnt_s = '0;
      end
    endcase
`ifdef PS2_BREAK_DECODE_EN
    if (frame_err_s) begin
      rel_s = 1'b0;
      ext_s = 1'b0;
    end else if (byte_valid_s) begin
      if (byte_out_s == 8'hE0) begin
        ext_s = 1'b1;
      end else if (byte_out_s == 8'hF0) begin
        rel_s = 1'b1;
      end else begin
        key_valid_s   = 1'b1;
        key_code_s    = byte_out_s;
        key_release_s = rel_r;
        key_ext_s     = ext_r;
        rel_s         = 1'b0;
        ext_s         = 1'b0;
      end
    end else begin
      key_valid_s = 1'b0;
    end
`endif
    busy_s = (state_s == RECV);
  end

  // Register FSM state and all outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      bitcnt_r   <= 4'd0;
      shift_r    <= 10'd0;
      to_cnt_r   <= '0;
      keycodeout <= '0;
      byte_out   <= 8'd0;
      err_code   <= 2'b00;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
`ifdef PS2_BREAK_DECODE_EN
      rel_r       <= 1'b0;
      ext_r       <= 1'b0;
      key_code    <= 8'd0;
      key_release <= 1'b0;
      key_ext     <= 1'b0;
      key_valid   <= 1'b0;
`endif
    end else begin
      state_r    <= state_s;
      bitcnt_r   <= bitcnt_s;
      shift_r    <= shift_s;
      to_cnt_r   <= to_cnt_s;
      keycodeout <= kc_s;
      byte_out   <= byte_out_s;
      err_code   <= err_code_s;
      byte_valid <= byte_valid_s;
      frame_err  <= frame_err_s;
      busy       <= busy_s;
`ifdef PS2_BREAK_DECODE_EN
      rel_r       <= rel_s;
      ext_r       <= ext_s;
      key_code    <= key_code_s;
      key_release <= key_release_s;
      key_ext     <= key_ext_s;
      key_valid   <= key_valid_s;
`endif
    end
  end

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Directed bench for ps2_frame_receiver; expected results are queued per frame and checked on each output pulse.
module tb_ps2_frame_receiver;
  localparam int FL    = 8;
  localparam int TC    = 500;
  localparam int HB    = 4;
  localparam int HALF  = 20;
  localparam int GAP   = 60;
  localparam int GLTCH = FL - 3;

  logic clk = 1'b0;
  logic rst, kclk, kdata;
  logic [8*HB-1:0] keycodeout;
  logic [7:0] byte_out;
  logic byte_valid, frame_err, busy;
  logic [1:0] err_code;
`ifdef PS2_BREAK_DECODE_EN
  logic [7:0] key_code;
  logic key_release, key_ext, key_valid;
  int kv_cnt;
  logic [7:0] kv_code;
  logic kv_rel, kv_ext;
`endif

  typedef struct {
    logic        is_err;
    logic [7:0]  bo;
    logic [31:0] kc;
    logic [1:0]  code;
  } exp_t;
  exp_t q[$];

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] m_kc;
  logic [7:0]  m_bo;
  logic [1:0]  m_err;

  ps2_frame_receiver #(.FILTER_LEN(FL), .TIMEOUT_CYC(TC), .HIST_BYTES(HB)) dut (
    .clk(clk), .rst(rst), .kclk(kclk), .kdata(kdata),
    .keycodeout(keycodeout), .byte_out(byte_out), .byte_valid(byte_valid),
    .frame_err(frame_err), .err_code(err_code), .busy(busy)
`ifdef PS2_BREAK_DECODE_EN
    , .key_code(key_code), .key_release(key_release), .key_ext(key_ext), .key_valid(key_valid)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic exp_good(input logic [7:0] b);
    exp_t e;
    m_bo = b;
    m_kc = {m_kc[23:0], b};
    e.is_err = 1'b0; e.bo = m_bo; e.kc = m_kc; e.code = m_err;
    q.push_back(e);
  endtask

  task automatic exp_err(input logic [1:0] c);
    exp_t e;
    m_err = c;
    e.is_err = 1'b1; e.bo = m_bo; e.kc = m_kc; e.code = m_err;
    q.push_back(e);
  endtask

  task automatic send_bit(input logic b, input logic glitch);
    int hi;
    kdata = b;
    hi = HALF;
    if (glitch) begin
      repeat (HALF / 2) @(negedge clk);
      kclk = 1'b0;
      repeat (GLTCH) @(negedge clk);
      kclk = 1'b1;
      hi = HALF - HALF / 2 - GLTCH;
    end
    repeat (hi) @(negedge clk);
    kclk = 1'b0;
    repeat (HALF) @(negedge clk);
    kclk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pflip, input logic stop, input logic glitch);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i], glitch && (i % 3 == 1));
    send_bit((~^d) ^ pflip, 1'b0);
    send_bit(stop, 1'b0);
    kdata = 1'b1;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic good(input logic [7:0] d);
    exp_good(d);
    send_frame(d, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk({tag, "_kc"}, keycodeout, 32'd0);
    chk({tag, "_bo"}, {24'd0, byte_out}, 32'd0);
    chk({tag, "_flags"}, {28'd0, err_code, byte_valid | frame_err, busy}, 32'd0);
`ifdef PS2_BREAK_DECODE_EN
    chk({tag, "_key"}, {21'd0, key_code, key_release, key_ext, key_valid}, 32'd0);
    kv_cnt = 0;
`endif
    rst = 1'b0;
    m_kc = 32'd0; m_bo = 8'd0; m_err = 2'b00;
    q.delete();
  endtask

  // Output monitor: every pulse must match the oldest queued expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!rst && (byte_valid || frame_err)) begin
      chk("onehot", {31'd0, byte_valid & frame_err}, 32'd0);
      if (q.size() == 0) begin
        chk("spurious", {30'd0, byte_valid, frame_err}, 32'd0);
      end else begin
        e = q.pop_front();
        chk("kind", {31'd0, frame_err}, {31'd0, e.is_err});
        chk("byte_out", {24'd0, byte_out}, {24'd0, e.bo});
        chk("keycodeout", keycodeout, e.kc);
        chk("err_code", {30'd0, err_code}, {30'd0, e.code});
      end
    end
  end

`ifdef PS2_BREAK_DECODE_EN
  always @(posedge clk) begin
    #1;
    if (!rst && key_valid) begin
      kv_cnt++;
      kv_code = key_code;
      kv_rel  = key_release;
      kv_ext  = key_ext;
      chk("kv_with_bv", {31'd0, byte_valid}, 32'd1);
    end
  end
`endif

  initial begin
    int n;
    rst = 1'b1; kclk = 1'b1; kdata = 1'b1;
    m_kc = 32'd0; m_bo = 8'd0; m_err = 2'b00;
    repeat (3) @(negedge clk);
    do_reset("reset");
    repeat (20) @(negedge clk);

    good(8'h1C);
    chk("t1_kc", keycodeout, 32'h0000001C);
    chk("t1_err", {30'd0, err_code}, 32'd0);
    chk("t1_drain", q.size(), 32'd0);

    do_reset("reset2");
    good(8'hF0);
    good(8'h1C);
    chk("t2_kc", keycodeout, 32'h0000F01C);
`ifdef PS2_BREAK_DECODE_EN
    chk("t2_kv_cnt", kv_cnt, 32'd1);
    chk("t2_key", {21'd0, kv_code, kv_rel, kv_ext, 1'b0}, {21'd0, 8'h1C, 1'b1, 1'b0, 1'b0});
`endif

    exp_err(2'b10);
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
    exp_err(2'b01);
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    chk("t3_kc", keycodeout, 32'h0000F01C);
    chk("t3_drain", q.size(), 32'd0);

    exp_err(2'b11);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    kdata = 1'b1;
    repeat (HALF) @(negedge clk);
    kclk = 1'b0;
    n = 0;
    while (!frame_err && n < 3 * TC) begin
      @(posedge clk);
      #1;
      n++;
      if (n == HALF) kclk = 1'b1;
    end
    kclk = 1'b1;
    chk("t4_latency", n, FL + 3 + TC);
    @(negedge clk);
    chk("t4_busy", {31'd0, busy}, 32'd0);
    chk("t4_err", {30'd0, err_code}, 32'd3);
    repeat (GAP) @(negedge clk);
    good(8'h29);
    chk("t4_kc", keycodeout, 32'h00F01C29);

    exp_good(8'h5A);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b1);
    chk("t5_glitch_bo", {24'd0, byte_out}, 32'h5A);

    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    chk("t5_busy_mid", {31'd0, busy}, 32'd1);
    do_reset("midrst");
    repeat (GAP) @(negedge clk);
    good(8'h1C);
    chk("t5_kc", keycodeout, 32'h0000001C);

    do_reset("reset3");
    good(8'hE0);
    good(8'hF0);
    good(8'h75);
    chk("t6_kc", keycodeout, 32'h00E0F075);
`ifdef PS2_BREAK_DECODE_EN
    chk("t6_kv_cnt", kv_cnt, 32'd1);
    chk("t6_key", {21'd0, kv_code, kv_rel, kv_ext, 1'b0}, {21'd0, 8'h75, 1'b1, 1'b1, 1'b0});
`endif
    chk("final_drain", q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
